// File: rtl/booth_multiplier_if.sv
// Operand/result bus shared between the arithmetic unit and the Booth multiplier.
// The master issues start with the operands; the multiplier (slave) returns busy, done and product.
interface booth_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, x, y,
    input  busy, done, product
  );

  modport slave (
    input  start, x, y,
    output busy, done, product
  );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential signed radix-4 Booth multiplier: one add step and one 2-bit shift step per
// recoded digit, WIDTH/2 digits in total; the product is registered and held until the next completion.
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_b,
  booth_multiplier_if.slave  bus
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_multiplier: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]      a;
  logic [WIDTH-1:0]   q;
  logic               q_m1;
  logic [AW-1:0]      m;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] product_r;

  logic [2:0]         digit;
  logic [AW-1:0]      addend;
  logic               subtract;
  logic [AW-1:0]      a_sum;
  logic [AW+WIDTH:0]  shift_vec;
  logic [AW-1:0]      a_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               q_m1_sh;
  logic               last_iter;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = last_iter ? DONE : ADD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      IDLE:    ;
      ADD,
      SHIFT:   bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  assign digit     = {q[1:0], q_m1};
  assign last_iter = (cnt == CNT_LAST);

  always_comb begin
    addend   = '0;
    subtract = 1'b0;
    unique case (digit)
      3'b001, 3'b010: addend = m;
      3'b011:         addend = m << 1;
      3'b100: begin
        addend   = ~(m << 1);
        subtract = 1'b1;
      end
      3'b101, 3'b110: begin
        addend   = ~m;
        subtract = 1'b1;
      end
      default:        addend = '0;
    endcase
  end

  // Two's-complement subtract as invert-plus-one; the carry out of AW bits is dropped.
  assign a_sum = a + addend + AW'(subtract);

  assign shift_vec = $signed({a, q, q_m1}) >>> 2;
  assign a_sh      = shift_vec[AW+WIDTH:WIDTH+1];
  assign q_sh      = shift_vec[WIDTH:1];
  assign q_m1_sh   = shift_vec[0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a         <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      m         <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          m    <= {{2{bus.x[WIDTH-1]}}, bus.x};
          q    <= bus.y;
          a    <= '0;
          q_m1 <= 1'b0;
          cnt  <= '0;
        end
        ADD: a <= a_sum;
        SHIFT: begin
          a    <= a_sh;
          q    <= q_sh;
          q_m1 <= q_m1_sh;
          // The final shift leaves the exact product in the low 2*WIDTH bits of {A,Q}.
          if (last_iter) product_r <= {a_sh[WIDTH-1:0], q_sh};
          else           cnt       <= cnt + 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.product = product_r;

endmodule

// File: tb/tb_booth_multiplier.sv
// Randomised scoreboard bench for booth_multiplier: accepted requests push the exact signed
// product into a queue, and a monitor pops and compares on every done pulse.
module tb_booth_multiplier;

  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] prod;
    longint         acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;

  booth_multiplier_if #(.WIDTH(W)) bus ();

  booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     done_cnt = 0;
  exp_t   sb[$];
  logic [2*W-1:0] held = '0;
  logic   prev_done = 1'b0;

  task automatic check(input string name, input bit ok,
                       input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor then request sampler; inputs are only ever driven just after a rising edge.
  always @(negedge clk) begin
    if (rst_b) begin
      if (bus.done) begin
        done_cnt++;
        check("done_single_cycle", !prev_done, 64'(prev_done), 64'd0);
        check("busy_in_done", bus.busy == 1'b1, 64'(bus.busy), 64'd1);
        if (sb.size() == 0) begin
          check("unexpected_done", 1'b0, 64'(bus.done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", bus.product == e.prod, bus.product, e.prod);
          check("latency", (cyc - e.acc_cyc) == longint'(W), 64'(cyc - e.acc_cyc), 64'(W));
          held = e.prod;
        end
      end else begin
        check("product_hold", bus.product == held, bus.product, held);
      end
      if (bus.start && !bus.busy) begin
        exp_t n;
        n.prod    = 64'(longint'($signed(bus.x)) * longint'($signed(bus.y)));
        n.acc_cyc = cyc + 1;
        sb.push_back(n);
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (!bus.busy && sb.size() == 0) return;
    end
    check("wait_idle_timeout", 1'b0, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    wait_idle();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x     = a;
    bus.y     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.x = $urandom;
      bus.y = $urandom;
    end
    wait_idle();
  endtask

  function automatic logic [W-1:0] pick_operand();
    unique case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0]   dx [5] = '{32'd4802, -32'sd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [W-1:0]   dy [5] = '{32'd172,  32'd3,   32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
  logic [2*W-1:0] dp [5] = '{64'h0000_0000_000C_9A58, 64'hFFFF_FFFF_FFFF_FFEB, 64'h1,
                             64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000};

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;

    #23;
    check("reset_busy", bus.busy == 1'b0, 64'(bus.busy), 64'd0);
    check("reset_done", bus.done == 1'b0, 64'(bus.done), 64'd0);
    check("reset_product", bus.product == '0, bus.product, 64'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(dx[i], dy[i], 1'b1);
      check($sformatf("directed_%0d", i), bus.product == dp[i], bus.product, dp[i]);
    end

    // start held across a whole operation: one result inside the window, a second
    // acceptance in the IDLE cycle right after done.
    wait_idle();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x     = 32'd5;
    bus.y     = 32'd6;
    d0        = done_cnt;
    repeat (40) @(posedge clk);
    #1 bus.start = 1'b0;
    check("held_start_one_done", (done_cnt - d0) == 1, 64'(done_cnt - d0), 64'd1);
    wait_idle();
    check("held_start_second_done", (done_cnt - d0) == 2, 64'(done_cnt - d0), 64'd2);
    check("held_start_product", bus.product == 64'd30, bus.product, 64'd30);

    // Reset in the middle of a 12*12 operation.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x     = 32'd12;
    bus.y     = 32'd12;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk);
    #1 rst_b = 1'b0;
    sb.delete();
    held = '0;
    #1;
    check("abort_busy", bus.busy == 1'b0, 64'(bus.busy), 64'd0);
    check("abort_done", bus.done == 1'b0, 64'(bus.done), 64'd0);
    check("abort_product", bus.product == '0, bus.product, 64'd0);
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (40) @(posedge clk);
    check("abort_no_done", done_cnt == d0, 64'(done_cnt - d0), 64'd0);
    run_op(32'd9, -32'sd9, 1'b1);
    check("after_abort_product", bus.product == 64'hFFFF_FFFF_FFFF_FFAF,
          bus.product, 64'hFFFF_FFFF_FFFF_FFAF);

    for (int i = 0; i < 1000; i++) begin
      run_op(pick_operand(), pick_operand(), 1'b1);
    end

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
